// File: rtl/aes_sim_pkg.sv
// aes_sim_pkg: shared widths, depths and decrypt FSM state type for the simulation cipher blocks
package aes_sim_pkg;
    localparam int DATA_W     = 128;
    localparam int FIFO_DEPTH = 4;
    localparam int IDX_W      = 8;
    typedef enum logic [1:0] {IDLE, RUN, EXH} dec_state_e;
endpackage

// File: rtl/aes_stream_decrypt_if.sv
// aes_stream_decrypt_if: key-load, ciphertext-in and plaintext-out channels of the stream decryptor
//   master: drives load_key/key, in_valid/ciphertext, out_ready
//   slave:  drives in_ready, out_valid/plaintext, key_loaded, key_exhausted
interface aes_stream_decrypt_if;
    logic                          load_key;
    logic [aes_sim_pkg::DATA_W-1:0] key;
    logic                          in_valid;
    logic                          in_ready;
    logic [aes_sim_pkg::DATA_W-1:0] ciphertext;
    logic                          out_valid;
    logic                          out_ready;
    logic [aes_sim_pkg::DATA_W-1:0] plaintext;
    logic                          key_loaded;
    logic                          key_exhausted;
    modport master (
        output load_key, key, in_valid, ciphertext, out_ready,
        input  in_ready, out_valid, plaintext, key_loaded, key_exhausted
    );
    modport slave (
        input  load_key, key, in_valid, ciphertext, out_ready,
        output in_ready, out_valid, plaintext, key_loaded, key_exhausted
    );
endinterface

// File: rtl/aes_sim_sync_fifo.sv
// aes_sim_sync_fifo: W x DEPTH synchronous FIFO with flush; head reads 0 when empty
//   clk, rst_n (async active-low), flush, push, pop, din -> dout (head), full, empty
module aes_sim_sync_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          push_ok, pop_ok;
    assign full    = cnt == CW'(DEPTH);
    assign empty   = cnt == '0;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk)
        if (push_ok && !flush) mem[wr_ptr] <= din;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_ok);
            rd_ptr <= rd_ptr + PW'(pop_ok);
            cnt    <= cnt + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/aes_stream_decrypt.sv
// aes_stream_decrypt: stream decryptor, block k after a key load gives pt = ct ^ (key << k)
//   clk, rst_n (async active-low), bus (aes_stream_decrypt_if.slave)
//   Optional AES_DEC_KEY_EXHAUST_EN: stop accepting once the key has shifted out (EXH state).
module aes_stream_decrypt
    import aes_sim_pkg::*;
(
    input logic                 clk,
    input logic                 rst_n,
    aes_stream_decrypt_if.slave bus
);
`ifdef AES_DEC_KEY_EXHAUST_EN
    localparam bit EXH_EN = 1'b1;
`else
    localparam bit EXH_EN = 1'b0;
`endif
    dec_state_e        state_q, state_d;
    logic [DATA_W-1:0] cur_key;
    logic [IDX_W-1:0]  idx;
    logic              full, empty, in_rdy, accept, pop, at_end;
    // in_rdy looks only at registered FIFO state so it never depends on out_ready
    assign in_rdy  = state_q == RUN && !full && !bus.load_key;
    assign accept  = bus.in_valid && in_rdy;
    // a key load flushes the FIFO, so a same-cycle pop is dropped
    assign pop     = !empty && bus.out_ready && !bus.load_key;
    assign at_end  = idx == IDX_W'(DATA_W);
    assign bus.in_ready      = in_rdy;
    assign bus.out_valid     = !empty;
    assign bus.key_loaded    = state_q != IDLE;
    assign bus.key_exhausted = EXH_EN && state_q == EXH;
    always_comb begin
        state_d = state_q;
        if (bus.load_key) state_d = RUN;
        else if (EXH_EN && accept && idx == IDX_W'(DATA_W - 1)) state_d = EXH;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_key <= '0;
            idx     <= '0;
        end else begin
            state_q <= state_d;
            if (bus.load_key) begin
                cur_key <= bus.key;
                idx     <= '0;
            end else if (accept) begin
                cur_key <= cur_key << 1;
                idx     <= at_end ? idx : idx + 1'b1;
            end
        end
    end
    aes_sim_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.load_key),
        .push  (accept),
        .pop   (pop),
        .din   (bus.ciphertext ^ cur_key),
        .dout  (bus.plaintext),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_aes_stream_decrypt.sv
// tb_aes_stream_decrypt: directed + random stimulus checked against a queue-based reference model
module tb_aes_stream_decrypt;
    localparam int DW = 128;
    localparam int DEPTH = 4;
`ifdef AES_DEC_KEY_EXHAUST_EN
    localparam bit EXH_EN = 1'b1;
`else
    localparam bit EXH_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    aes_stream_decrypt_if bus ();
    aes_stream_decrypt dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [DW-1:0] m_key;
    int            m_n;
    bit            m_loaded, m_exh;
    logic [DW-1:0] q [$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_key = '0; m_n = 0; m_loaded = 0; m_exh = 0;
        q.delete();
    endtask

    // one clock cycle, entered and left at the falling edge
    task automatic cycle(input bit lk, input logic [DW-1:0] k, input bit iv,
                         input logic [DW-1:0] ct, input bit ordy);
        bit exp_rdy, acc, pp;
        bus.load_key = lk; bus.key = k; bus.in_valid = iv;
        bus.ciphertext = ct; bus.out_ready = ordy;
        #1;
        exp_rdy = m_loaded && !m_exh && q.size() < DEPTH && !lk;
        chk("in_ready", DW'(bus.in_ready), DW'(exp_rdy));
        acc = iv && exp_rdy;
        pp  = q.size() > 0 && ordy && !lk;
        @(posedge clk);
        if (lk) begin
            q.delete(); m_key = k; m_n = 0; m_loaded = 1; m_exh = 0;
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) begin
                q.push_back(ct ^ (m_key << m_n));
                if (m_n < DW) m_n++;
                if (EXH_EN && m_n == DW) m_exh = 1;
            end
        end
        #1;
        chk("out_valid", DW'(bus.out_valid), DW'(q.size() > 0));
        if (q.size() > 0) chk("plaintext", bus.plaintext, q[0]);
        chk("key_loaded", DW'(bus.key_loaded), DW'(m_loaded));
        chk("key_exhausted", DW'(bus.key_exhausted), DW'(m_exh));
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy);
        cycle(0, '0, 0, '0, ordy);
    endtask

    initial begin
        logic [DW-1:0] ct;
        model_reset();
        bus.load_key = 0; bus.key = '0; bus.in_valid = 0;
        bus.ciphertext = '0; bus.out_ready = 0;
        #1;
        chk("rst_in_ready", DW'(bus.in_ready), '0);
        chk("rst_out_valid", DW'(bus.out_valid), '0);
        chk("rst_plaintext", bus.plaintext, '0);
        chk("rst_key_loaded", DW'(bus.key_loaded), '0);
        chk("rst_key_exhausted", DW'(bus.key_exhausted), '0);
        @(negedge clk);
        rst_n = 1;
        // no key yet: input refused
        cycle(0, '0, 1, rnd128(), 1);

        // round trip with key 1
        cycle(1, DW'(1), 0, '0, 1);
        cycle(0, '0, 1, DW'('h3), 1);
        chk("rt_pt0", bus.plaintext, DW'('h2));
        cycle(0, '0, 1, DW'('h6), 1);
        chk("rt_pt1", bus.plaintext, DW'('h4));
        cycle(0, '0, 1, DW'('hC), 1);
        chk("rt_pt2", bus.plaintext, DW'('h8));
        idle(1);

        // backpressure: 5 offered, 4 taken, order preserved on drain
        cycle(1, rnd128(), 0, '0, 0);
        for (int i = 0; i < 5; i++) cycle(0, '0, 1, rnd128(), 0);
        chk("bp_full_refuse", DW'(bus.in_ready), '0);
        for (int i = 0; i < 5; i++) idle(1);

        // load during traffic with 3 queued
        cycle(1, rnd128(), 0, '0, 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 1, rnd128(), 0);
        cycle(1, rnd128(), 1, rnd128(), 1);
        chk("ld_flushed", DW'(bus.out_valid), '0);
        cycle(0, '0, 1, rnd128(), 0);
        idle(1);

        // simultaneous push/pop at full-1 and at empty
        cycle(1, rnd128(), 0, '0, 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 1, rnd128(), 0);
        cycle(0, '0, 1, rnd128(), 1);
        cycle(0, '0, 1, rnd128(), 0);
        chk("pp_full_after", DW'(bus.in_ready), '0);
        for (int i = 0; i < 4; i++) idle(1);
        cycle(0, '0, 1, rnd128(), 1);
        cycle(0, '0, 1, rnd128(), 1);
        idle(1);

        // exhaustion with all-ones key
        cycle(1, '1, 0, '0, 1);
        for (int i = 0; i < DW; i++) cycle(0, '0, 1, rnd128(), 1);
        ct = rnd128();
        cycle(0, '0, 1, ct, 1);
        if (EXH_EN) begin
            chk("exh_flag", DW'(bus.key_exhausted), DW'(1));
        end else begin
            chk("pass_through", bus.plaintext, ct);
        end
        idle(1);
        idle(1);

        // random traffic
        cycle(1, rnd128(), 0, '0, 0);
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 39) == 0, rnd128(), $urandom_range(0, 3) != 0,
                  rnd128(), $urandom_range(0, 2) != 0);

        // reset mid-stream with 2 entries queued
        cycle(1, rnd128(), 0, '0, 0);
        cycle(0, '0, 1, rnd128(), 0);
        cycle(0, '0, 1, rnd128(), 0);
        chk("pre_rst_valid", DW'(bus.out_valid), DW'(1));
        #1;
        rst_n = 0;
        #1;
        chk("mid_rst_out_valid", DW'(bus.out_valid), '0);
        chk("mid_rst_in_ready", DW'(bus.in_ready), '0);
        chk("mid_rst_plaintext", bus.plaintext, '0);
        chk("mid_rst_key_loaded", DW'(bus.key_loaded), '0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        cycle(1, rnd128(), 0, '0, 0);
        cycle(0, '0, 1, rnd128(), 1);
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
